// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared constants and helpers for the bin2bcd_sat converter
// Purpose: FSM state encodings, the saturation digit and a counter-width helper.
// Ports:   none (package).
package bin2bcd_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'b00;
   localparam state_t OP   = 2'b01;
   localparam state_t DONE = 2'b10;

   localparam logic [3:0] DIGIT_NINE = 4'h9;

   // Number of bits needed to hold values 0..value-1.
   function automatic int clog2(input int value);
      int bits;
      bits = 0;
      while ((1 << bits) < value) begin
         bits = bits + 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - one BCD digit add-3-if-at-least-5 correction
// Purpose: combinational shift-and-add-3 digit correction, result taken mod 16.
// Ports:   din  - working digit before correction
//          dout - din + 3 when din >= 5, else din
module bcd_digit_adj (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   always_comb begin
      dout = din;
      if (din >= 4'd5) begin
         dout = din + 4'd3;
      end
   end

endmodule

// File: rtl/bin2bcd_sat.sv
// rtl/bin2bcd_sat.sv - multi-cycle binary-to-BCD converter with sign, saturation and blanking
// Purpose: converts a W-bit (optionally two's-complement) operand into N BCD digits,
//          one shift per cycle, saturating to all nines when the magnitude does not fit.
// Ports:   clk, reset (sync, active-low)
//          start/bin       - request and operand, taken only while ready=1
//          ready/done_tick - idle indication and one-cycle completion pulse
//          bcd/sign/overflow/blank - result registers, held until the next commit
module bin2bcd_sat
   import bin2bcd_pkg::*;
#(
   parameter int W      = 16,
   parameter int N      = 5,
   parameter int SIGNED = 0
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [W-1:0]   bin,
   output logic           ready,
   output logic           done_tick,
   output logic [4*N-1:0] bcd,
   output logic           sign,
   output logic           overflow,
   output logic [N-1:0]   blank
);

   localparam int CW = clog2(W + 1);
   localparam logic [N-1:0] BLANK_RST = ~N'(1);

   state_t         state_q, state_d;
   logic [W-1:0]   shift_q, shift_d;
   logic [4*N-1:0] digits_q, digits_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           ovf_q, ovf_d;
   logic           sign_int_q, sign_int_d;
   logic [4*N-1:0] bcd_q, bcd_d;
   logic           sign_q, sign_d;
   logic           overflow_q, overflow_d;
   logic [N-1:0]   blank_q, blank_d;
   logic           done_q, done_d;

   logic [4*N-1:0] adj;
   logic [4*N-1:0] step_digits;
   logic           step_ovf;
   logic [W-1:0]   mag;
   logic           last_op;
   logic           zero_run;

   for (genvar g = 0; g < N; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (digits_q[4*g +: 4]),
         .dout (adj[4*g +: 4])
      );
   end

   // State register plus all datapath registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         digits_q   <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         sign_int_q <= 1'b0;
         bcd_q      <= '0;
         sign_q     <= 1'b0;
         overflow_q <= 1'b0;
         blank_q    <= BLANK_RST;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         digits_q   <= digits_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         sign_int_q <= sign_int_d;
         bcd_q      <= bcd_d;
         sign_q     <= sign_d;
         overflow_q <= overflow_d;
         blank_q    <= blank_d;
         done_q     <= done_d;
      end
   end

   assign last_op = (state_q == OP) && (cnt_q == CW'(1));

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = OP;
         OP:      if (last_op) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode; the completion pulse is registered off the DONE state.
   always_comb begin
      ready  = (state_q == IDLE);
      done_d = (state_q == DONE);
   end

   assign done_tick = done_q;
   assign bcd       = bcd_q;
   assign sign      = sign_q;
   assign overflow  = overflow_q;
   assign blank     = blank_q;

   // Datapath: load, shift-and-add-3 step, commit with saturation.
   always_comb begin
      // The two's-complement negate of the most negative value wraps to
      // 2^(W-1), which is exactly its magnitude when read as unsigned.
      mag = bin;
      if (SIGNED != 0 && bin[W-1]) begin
         mag = ~bin + W'(1);
      end

      // Digit 0 takes the shift MSB; the adjusted top digit's bit 3 falls off.
      step_digits = {adj[4*N-2:0], shift_q[W-1]};
      step_ovf    = ovf_q | adj[4*N-1];

      shift_d    = shift_q;
      digits_d   = digits_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      sign_int_d = sign_int_q;
      bcd_d      = bcd_q;
      sign_d     = sign_q;
      overflow_d = overflow_q;
      blank_d    = blank_q;
      zero_run   = 1'b1;

      if (state_q == IDLE && start) begin
         shift_d    = mag;
         digits_d   = '0;
         cnt_d      = CW'(W);
         ovf_d      = 1'b0;
         sign_int_d = (SIGNED != 0) ? bin[W-1] : 1'b0;
      end else if (state_q == OP) begin
         shift_d  = {shift_q[W-2:0], 1'b0};
         digits_d = step_digits;
         ovf_d    = step_ovf;
         cnt_d    = cnt_q - CW'(1);
      end

      if (last_op) begin
         overflow_d = step_ovf;
         bcd_d      = step_ovf ? {N{DIGIT_NINE}} : step_digits;
         // A zero result never reads as negative; saturated values keep the sign.
         sign_d     = sign_int_q & (step_ovf | (|step_digits));
         // Walk down from the top digit; a bit stays set while everything above is zero.
         for (int i = N - 1; i >= 1; i--) begin
            zero_run   = zero_run & (bcd_d[4*i +: 4] == 4'd0);
            blank_d[i] = zero_run;
         end
         blank_d[0] = 1'b0;
      end
   end

endmodule

// File: tb/tb_bin2bcd_sat.sv
// tb/tb_bin2bcd_sat.sv - self-checking bench for bin2bcd_sat in three configurations
module tb_bin2bcd_sat;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] bin;

   logic        ready_a, done_a, sign_a, ovf_a;
   logic [19:0] bcd_a;
   logic [4:0]  blank_a;
   logic        ready_b, done_b, sign_b, ovf_b;
   logic [15:0] bcd_b;
   logic [3:0]  blank_b;
   logic        ready_c, done_c, sign_c, ovf_c;
   logic [19:0] bcd_c;
   logic [4:0]  blank_c;

   logic [51:0] obs_a, obs_b, obs_c;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bin2bcd_sat #(.W(16), .N(5), .SIGNED(0)) u_dut_a (
      .clk(clk), .reset(reset), .start(start), .bin(bin),
      .ready(ready_a), .done_tick(done_a), .bcd(bcd_a),
      .sign(sign_a), .overflow(ovf_a), .blank(blank_a)
   );

   bin2bcd_sat #(.W(16), .N(4), .SIGNED(0)) u_dut_b (
      .clk(clk), .reset(reset), .start(start), .bin(bin),
      .ready(ready_b), .done_tick(done_b), .bcd(bcd_b),
      .sign(sign_b), .overflow(ovf_b), .blank(blank_b)
   );

   bin2bcd_sat #(.W(16), .N(5), .SIGNED(1)) u_dut_c (
      .clk(clk), .reset(reset), .start(start), .bin(bin),
      .ready(ready_c), .done_tick(done_c), .bcd(bcd_c),
      .sign(sign_c), .overflow(ovf_c), .blank(blank_c)
   );

   // Result word layout: {40-bit bcd, sign, overflow, 10-bit blank}.
   assign obs_a = {20'b0, bcd_a, sign_a, ovf_a, 5'b0, blank_a};
   assign obs_b = {24'b0, bcd_b, sign_b, ovf_b, 6'b0, blank_b};
   assign obs_c = {20'b0, bcd_c, sign_c, ovf_c, 5'b0, blank_c};

   // Decimal reference: magnitude, clamp to 10^n-1, peel digits with % and /.
   function automatic logic [51:0] model_word(input logic [15:0] b, input int n, input bit sm);
      longint mag, lim, v, p;
      logic [39:0] d;
      logic [9:0]  bl;
      logic        s, o;
      mag = (sm && b[15]) ? (65536 - longint'(b)) : longint'(b);
      lim = 1;
      for (int i = 0; i < n; i++) lim = lim * 10;
      lim = lim - 1;
      o = (mag > lim);
      v = o ? lim : mag;
      d = '0;
      p = v;
      for (int i = 0; i < n; i++) begin
         d[4*i +: 4] = 4'(p % 10);
         p = p / 10;
      end
      bl = '0;
      p  = 10;
      for (int i = 1; i < n; i++) begin
         bl[i] = (v < p);
         p = p * 10;
      end
      s = sm && b[15] && (mag != 0);
      return {d, s, o, bl};
   endfunction

   function automatic logic [51:0] rst_word(input int n);
      logic [9:0] bl;
      bl = 10'((1 << n) - 2);
      return {40'b0, 1'b0, 1'b0, bl};
   endfunction

   task automatic wait_edge();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one edge and wait (bounded) for done_tick on the N=5 unsigned instance.
   task automatic run_conv(input logic [15:0] b, output bit ok);
      bin   = b;
      start = 1'b1;
      wait_edge();
      start = 1'b0;
      bin   = 16'($urandom);
      ok    = 1'b0;
      for (int k = 0; k < 40; k++) begin
         wait_edge();
         if (done_a) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      bin   = '0;
      wait_edge();
      wait_edge();
      reset = 1'b1;
      n_cmp++;
      if ({ready_a, ready_b, ready_c, done_a, done_b, done_c} !== 6'b111000) begin
         n_err++;
         $display("FAIL reset_handshake: got %b expected 111000",
                  {ready_a, ready_b, ready_c, done_a, done_b, done_c});
      end
      n_cmp++;
      if (obs_a !== rst_word(5)) begin n_err++; $display("FAIL reset_a: got %h expected %h", obs_a, rst_word(5)); end
      n_cmp++;
      if (obs_b !== rst_word(4)) begin n_err++; $display("FAIL reset_b: got %h expected %h", obs_b, rst_word(4)); end
      n_cmp++;
      if (obs_c !== rst_word(5)) begin n_err++; $display("FAIL reset_c: got %h expected %h", obs_c, rst_word(5)); end
   endtask

   task automatic test_latency();
      logic [15:0] b;
      b     = 16'd65535;
      bin   = b;
      start = 1'b1;
      for (int k = 0; k < 22; k++) begin
         wait_edge();
         if (k == 0) begin
            start = 1'b0;
            bin   = 16'h1234;
         end
         n_cmp++;
         if ({done_a, done_b, done_c} !== {3{k == 17}}) begin
            n_err++;
            $display("FAIL latency_done k=%0d: got %b expected %b", k, {done_a, done_b, done_c}, {3{k == 17}});
         end
         n_cmp++;
         if (ready_a !== (k >= 17)) begin
            n_err++;
            $display("FAIL latency_ready k=%0d: got %b expected %b", k, ready_a, (k >= 17));
         end
         if (k == 17) begin
            n_cmp++;
            if (obs_a !== model_word(b, 5, 0)) begin n_err++; $display("FAIL lat_a: got %h expected %h", obs_a, model_word(b, 5, 0)); end
            n_cmp++;
            if (obs_b !== model_word(b, 4, 0)) begin n_err++; $display("FAIL lat_b: got %h expected %h", obs_b, model_word(b, 4, 0)); end
            n_cmp++;
            if (obs_c !== model_word(b, 5, 1)) begin n_err++; $display("FAIL lat_c: got %h expected %h", obs_c, model_word(b, 5, 1)); end
         end
      end
      // Results must stay put while idle.
      n_cmp++;
      if (obs_a !== model_word(b, 5, 0)) begin n_err++; $display("FAIL hold_a: got %h expected %h", obs_a, model_word(b, 5, 0)); end
   endtask

   task automatic test_directed();
      logic [15:0] tbl [10] = '{16'd12345, 16'd9999, 16'h8000, 16'hFFFF, 16'd0,
                                16'd42, 16'd10000, 16'h7FFF, 16'hD8F1, 16'd10};
      bit ok;
      foreach (tbl[i]) begin
         run_conv(tbl[i], ok);
         n_cmp++;
         if (!ok) begin n_err++; $display("FAIL dir_timeout bin=%h: got no done_tick expected done_tick", tbl[i]); end
         n_cmp++;
         if (obs_a !== model_word(tbl[i], 5, 0)) begin n_err++; $display("FAIL dir_a bin=%h: got %h expected %h", tbl[i], obs_a, model_word(tbl[i], 5, 0)); end
         n_cmp++;
         if (obs_b !== model_word(tbl[i], 4, 0)) begin n_err++; $display("FAIL dir_b bin=%h: got %h expected %h", tbl[i], obs_b, model_word(tbl[i], 4, 0)); end
         n_cmp++;
         if (obs_c !== model_word(tbl[i], 5, 1)) begin n_err++; $display("FAIL dir_c bin=%h: got %h expected %h", tbl[i], obs_c, model_word(tbl[i], 5, 1)); end
      end
   endtask

   task automatic test_back_to_back();
      int ticks, first_k, second_k;
      bit ok;
      ticks = 0; first_k = -1; second_k = -1;
      bin   = 16'd0;
      start = 1'b1;
      for (int k = 0; k < 40; k++) begin
         wait_edge();
         n_cmp++;
         if ({ready_a, done_a} !== {2{(k % 18) == 17}}) begin
            n_err++;
            $display("FAIL b2b_handshake k=%0d: got %b expected %b", k, {ready_a, done_a}, {2{(k % 18) == 17}});
         end
         if (done_a) begin
            ticks++;
            if (first_k < 0) first_k = k; else if (second_k < 0) second_k = k;
         end
      end
      start = 1'b0;
      n_cmp++;
      if (ticks != 2 || (second_k - first_k) != 18) begin
         n_err++;
         $display("FAIL b2b_ticks: got %0d ticks gap %0d expected 2 ticks gap 18", ticks, second_k - first_k);
      end
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         wait_edge();
         if (done_a) begin ok = 1'b1; break; end
      end
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL b2b_drain: got no done_tick expected done_tick"); end
      n_cmp++;
      if (obs_c !== model_word(16'd0, 5, 1)) begin n_err++; $display("FAIL b2b_zero_c: got %h expected %h", obs_c, model_word(16'd0, 5, 1)); end
      n_cmp++;
      if (obs_a !== model_word(16'd0, 5, 0)) begin n_err++; $display("FAIL b2b_zero_a: got %h expected %h", obs_a, model_word(16'd0, 5, 0)); end
   endtask

   task automatic test_reset_mid_op();
      int ticks;
      bit ok;
      bin   = 16'd54321;
      start = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         wait_edge();
         if (k == 0) start = 1'b0;
         if (k == 7) reset = 1'b0;
      end
      reset = 1'b1;
      n_cmp++;
      if ({ready_a, done_a, ready_c, done_c} !== 4'b1010) begin
         n_err++;
         $display("FAIL midop_handshake: got %b expected 1010", {ready_a, done_a, ready_c, done_c});
      end
      n_cmp++;
      if (obs_a !== rst_word(5)) begin n_err++; $display("FAIL midop_clear_a: got %h expected %h", obs_a, rst_word(5)); end
      n_cmp++;
      if (obs_b !== rst_word(4)) begin n_err++; $display("FAIL midop_clear_b: got %h expected %h", obs_b, rst_word(4)); end
      ticks = 0;
      for (int k = 0; k < 25; k++) begin
         wait_edge();
         if (done_a || done_b || done_c) ticks++;
      end
      n_cmp++;
      if (ticks != 0) begin n_err++; $display("FAIL midop_no_done: got %0d ticks expected 0", ticks); end
      run_conv(16'd42, ok);
      n_cmp++;
      if (!ok || obs_a !== model_word(16'd42, 5, 0)) begin
         n_err++;
         $display("FAIL midop_recover: got %h (done %b) expected %h", obs_a, ok, model_word(16'd42, 5, 0));
      end
   endtask

   task automatic test_start_ignored();
      logic [15:0] b;
      int ticks;
      b     = 16'hA5C3;
      bin   = b;
      start = 1'b1;
      ticks = 0;
      for (int k = 0; k < 22; k++) begin
         wait_edge();
         start = (k == 4) || (k == 16);
         bin   = 16'($urandom);
         if (done_a) ticks++;
         if (k == 17) begin
            n_cmp++;
            if (obs_a !== model_word(b, 5, 0)) begin n_err++; $display("FAIL ignore_a: got %h expected %h", obs_a, model_word(b, 5, 0)); end
            n_cmp++;
            if (obs_c !== model_word(b, 5, 1)) begin n_err++; $display("FAIL ignore_c: got %h expected %h", obs_c, model_word(b, 5, 1)); end
         end
         if (k > 17) begin
            n_cmp++;
            if (ready_a !== 1'b1) begin n_err++; $display("FAIL ignore_no_queue k=%0d: got ready %b expected 1", k, ready_a); end
         end
      end
      start = 1'b0;
      n_cmp++;
      if (ticks != 1) begin n_err++; $display("FAIL ignore_ticks: got %0d expected 1", ticks); end
   endtask

   task automatic test_random();
      logic [15:0] b;
      bit ok;
      for (int i = 0; i < 30; i++) begin
         b = (i % 3 == 0) ? 16'($urandom_range(0, 10100)) : 16'($urandom);
         run_conv(b, ok);
         n_cmp++;
         if (!ok) begin n_err++; $display("FAIL rnd_timeout bin=%h: got no done_tick expected done_tick", b); end
         n_cmp++;
         if (obs_a !== model_word(b, 5, 0)) begin n_err++; $display("FAIL rnd_a bin=%h: got %h expected %h", b, obs_a, model_word(b, 5, 0)); end
         n_cmp++;
         if (obs_b !== model_word(b, 4, 0)) begin n_err++; $display("FAIL rnd_b bin=%h: got %h expected %h", b, obs_b, model_word(b, 4, 0)); end
         n_cmp++;
         if (obs_c !== model_word(b, 5, 1)) begin n_err++; $display("FAIL rnd_c bin=%h: got %h expected %h", b, obs_c, model_word(b, 5, 1)); end
      end
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      bin   = '0;
      test_reset();
      test_latency();
      test_directed();
      test_back_to_back();
      test_reset_mid_op();
      test_start_ignored();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
